// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle controller.
// Holds the state enum, opcode encodings and datapath mux select codes.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_CMP   = 2'b01;
  localparam logic [1:0] ALU_OP_SHIFT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] REG_DST_RT   = 2'b00;
  localparam logic [1:0] REG_DST_RD   = 2'b01;
  localparam logic [1:0] REG_DST_LINK = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC1 = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake between the controller (master) and memory (slave).
// mem_read/mem_write are strobes; mem_ready completes the access.
interface multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags the limit.
// Ports: clk, reset, clear, waiting in; expired out (0 if MEM_TIMEOUT=0).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset, clear, waiting};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
      logic [CNT_W-1:0] cnt_q;

      // Count holds the number of wait cycles already spent; the
      // controller gives up on a further unready cycle at the limit.
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          cnt_q <= '0;
        end else if (waiting && cnt_q != LIMIT) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign expired = waiting && (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with memory handshake.
// Ports: clk, reset, opcode, zero, mem (handshake), datapath controls,
// sticky illegal_op/bus_error, debug state. Optional perf counters
// instr_count/stall_count when MULTICYCLE_CONTROL_PERF_EN is defined.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  multicycle_control_if.master mem,
  output logic                pc_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                jump,
  output logic                branch,
  output logic                reg_write,
  output logic                sign_or_zero,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [2:0]          state
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
`endif
);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       ill_q, bus_q;
  logic       legal, in_mem, waiting, expired;

  assign legal   = (opcode >> 3) == '0;
  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign waiting = in_mem && !mem.mem_ready && !reset;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!waiting),
    .waiting(waiting),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= OP_ADD;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode[2:0];
        if (!legal) ill_q <= 1'b1;
      end
      if (expired) bus_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = MEM_TO_REG_ALU;
    alu_op        = ALU_OP_ADD;
    alu_src       = 1'b0;
    jump          = 1'b0;
    branch        = 1'b0;
    reg_write     = 1'b0;
    sign_or_zero  = 1'b1;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem.mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (op_q)
          OP_ADD: state_d = S_WB;
          OP_SLI: begin
            alu_op       = ALU_OP_SHIFT;
            alu_src      = 1'b1;
            sign_or_zero = 1'b0;
            state_d      = S_WB;
          end
          OP_ADDI: begin
            alu_op  = ALU_OP_IMM;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op  = ALU_OP_IMM;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = ALU_OP_CMP;
            branch   = 1'b1;
            pc_write = zero;
            state_d  = S_FETCH;
          end
          OP_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JAL: begin
            jump       = 1'b1;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = REG_DST_LINK;
            mem_to_reg = MEM_TO_REG_PC1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem.mem_read  = (op_q == OP_LW);
        mem.mem_write = (op_q != OP_LW);
        if (mem.mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (expired) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_ADD) ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = (op_q == OP_LW) ? MEM_TO_REG_MEM : MEM_TO_REG_ALU;
        state_d    = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset aborts whatever is in flight: no strobe or write this cycle.
    if (reset) begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = REG_DST_RT;
      mem_to_reg    = MEM_TO_REG_ALU;
      alu_op        = ALU_OP_ADD;
      alu_src       = 1'b0;
      jump          = 1'b0;
      branch        = 1'b0;
      reg_write     = 1'b0;
      sign_or_zero  = 1'b1;
      mem.mem_read  = 1'b0;
      mem.mem_write = 1'b0;
    end
  end

  assign illegal_op = ill_q && !reset;
  assign bus_error  = bus_q && !reset;
  assign state      = reset ? S_FETCH : state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] instr_q, stall_q;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_EXEC || state_q == S_MEM ||
                   state_q == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      if (retire) instr_q <= instr_q + 32'd1;
      if (waiting) stall_q <= stall_q + 32'd1;
    end
  end

  assign instr_count = reset ? '0 : instr_q;
  assign stall_count = reset ? '0 : stall_q;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a memory ready handshake.
- Drives the same datapath control set, plus PC/IR write enables, a branch-resolved PC write and trap/illegal flags.
- Sits between the instruction register and the shared datapath; one instance per core.

Parameters:
- OPCODE_W, 3, opcode width; opcodes with any bit above bit 2 set are illegal.
- MEM_TIMEOUT, 0, maximum cycles waiting for mem_ready; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy MEM_TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  opcode field of the instruction register; sampled in DECODE.
- zero  in  1  ALU zero flag; used in EXEC for beq.
- mem_ready  in  1  memory completes the current fetch/lw/sw this cycle.
- pc_write  out  1  update PC this cycle.
- ir_write  out  1  load instruction register this cycle.
- reg_dst  out  2  00 rt, 01 rd, 10 link register.
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+1.
- alu_op  out  2  00 add/R-type, 01 compare, 10 shift, 11 immediate add.
- alu_src  out  1  0 register, 1 immediate.
- jump, branch, mem_read, mem_write, reg_write, sign_or_zero  out  1 each  same meaning as the existing control set.
- illegal_op  out  1  sticky; illegal opcode decoded.
- bus_error  out  1  sticky; memory timeout.
- state  out  3  current state encoding, for debug.

Behaviour:
- States:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
  - Moore outputs, except pc_write, ir_write and reg_write, which are gated by mem_ready or zero where stated.
- Reset:
  - Next state is FETCH.
  - All outputs are 0 except sign_or_zero=1.
  - illegal_op, bus_error and the timeout counter are cleared.
  - Reset in any state, including TRAP or mid memory wait, aborts the instruction; no write enable is asserted in the reset cycle.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC+1), go to DECODE.
  - Otherwise stay in FETCH.
  - Zero-wait memory (mem_ready on the first cycle) is legal.
- DECODE:
  - Single cycle; latch opcode.
  - Illegal opcode → TRAP, setting illegal_op.
  - Otherwise → EXEC.
- EXEC, per opcode (encodings 000 add, 001 sli, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi):
  - add: alu_op=00, alu_src=0 → WB.
  - sli: alu_op=10, alu_src=1, sign_or_zero=0 → WB.
  - addi: alu_op=11, alu_src=1 → WB.
  - lw/sw: alu_op=11, alu_src=1 → MEM.
  - beq: alu_op=01, branch=1, pc_write=zero → FETCH.
  - j: jump=1, pc_write=1 → FETCH.
  - jal: jump=1, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 → FETCH.
- MEM:
  - lw: mem_read=1. sw: mem_write=1.
  - Hold the strobe until mem_ready.
  - lw → WB; sw → FETCH.
- WB:
  - reg_write=1.
  - add: reg_dst=01, mem_to_reg=00.
  - sli/addi: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.
  - → FETCH.
- Latencies with zero-wait memory:
  - add/sli/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - j/jal/beq: 3 cycles.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0 in those states.
  - When count==MEM_TIMEOUT with mem_ready=0 → TRAP, set bus_error, deassert all strobes.
  - mem_ready in the same cycle as the limit wins and completes normally.
- TRAP: all enables 0; remain until reset.
- Write enables are never asserted in two consecutive states for the same instruction, except pc_write (FETCH then EXEC for j/jal/beq).

Optional Feature:
- Macro: MULTICYCLE_CONTROL_PERF_EN.
- When defined:
  - Adds outputs instr_count (32) and stall_count (32).
  - instr_count increments on every transition into FETCH from EXEC/MEM/WB.
  - stall_count increments on every cycle in FETCH/MEM with mem_ready=0.
  - Both clear on reset and wrap modulo 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- control_pkg holds:
  - state_t enum.
  - Opcode constants OP_ADD..OP_ADDI.
  - ALU_OP_* constants.
  - REG_DST_* and MEM_TO_REG_* constants.
- Sub-module mem_wait_timer:
  - Parameters MEM_TIMEOUT, CNT_W.
  - Inputs: clk, reset, clear, waiting.
  - Output: expired.
  - Tied off (expired=0) when MEM_TIMEOUT=0.

Test Plan:
- Reset held 2 cycles, then add (000) with mem_ready=1 constant → states 0,1,2,4,0. WB shows reg_write=1, reg_dst=01. Total 4 cycles.
- lw (100) with mem_ready low for 3 cycles in MEM → mem_read held 4 cycles in MEM, then WB with mem_to_reg=01. Total 8 cycles.
- beq (110) run twice, zero=0 then zero=1 → EXEC pc_write=0, then 1. branch=1 both times; returns to FETCH.
- OPCODE_W=4, opcode 1010 → TRAP after DECODE. illegal_op=1 stays latched. Reset returns to FETCH with illegal_op=0.
- MEM_TIMEOUT=5, mem_ready stuck 0 in FETCH → after 5 wait cycles state=7, bus_error=1, mem_read=0.
- Reset asserted during MEM of sw → no mem_write in the reset cycle; next state FETCH. With MULTICYCLE_CONTROL_PERF_EN defined, counters read 0.
